// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and small helpers.
// PROG_LOADER_CKSUM_EN adds the trailing checksum state.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_HDR3,
    S_DATA,
`ifdef PROG_LOADER_CKSUM_EN
    S_CHK,
`endif
    S_RUN
  } state_t;

  // State entered once the last header/payload byte has been taken.
`ifdef PROG_LOADER_CKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_RUN;
`endif

  function automatic logic [7:0] cksum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream (valid/ready) and RAM byte write port of the program loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_d;

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_we, ram_addr, ram_d
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_we, ram_addr, ram_d
  );
endinterface

// File: rtl/prog_loader_ctr.sv
// ldr_ctr: loadable down-counter with zero flag, used for the remaining payload count.
module ldr_ctr #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic         zero
);
  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
    else if (dec)  q <= q - W'(1);
  end

  assign zero = (q == '0);
endmodule

// File: rtl/prog_loader.sv
// Program loader: parses ADDR/LEN header from a host byte stream, writes payload to RAM,
// then pulses run. `define PROG_LOADER_CKSUM_EN to require a trailing 8-bit sum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned AUTO_RUN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_idle,
  prog_loader_if.slave    bus,
  output logic            run,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam bit END_RUN = (AUTO_RUN != 0) && (S_END == S_RUN);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cnt_d;
  logic [7:0]        cnt_lo;
  logic              xfer;
  logic              cnt_zero;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_d_q;
  logic              run_q;
  logic              done_q;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        sum;
  logic              err_q;
`endif

  assign bus.in_ready = cpu_idle & ~rst & (state != S_RUN);
  assign xfer         = bus.in_valid & bus.in_ready;
  assign cnt_d        = ADDR_W'({bus.in_data, cnt_lo});

  // Counter holds bytes-remaining minus one, so zero marks the final payload byte.
  ldr_ctr #(.W(ADDR_W)) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (xfer && (state == S_HDR3)),
    .dec  (xfer && (state == S_DATA)),
    .d    (cnt_d - ADDR_W'(1)),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HDR0;
      addr       <= '0;
      cnt_lo     <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_d_q    <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
      sum        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      ram_we_q <= 1'b0;
      run_q    <= 1'b0;
      case (state)
        S_HDR0: begin
`ifdef PROG_LOADER_CKSUM_EN
          sum <= '0;
`endif
          if (xfer) begin
            addr   <= ADDR_W'(bus.in_data);
            done_q <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
            err_q  <= 1'b0;
`endif
            state  <= S_HDR1;
          end
        end
        S_HDR1: if (xfer) begin
          addr  <= ADDR_W'({bus.in_data, addr[7:0]});
          state <= S_HDR2;
        end
        S_HDR2: if (xfer) begin
          cnt_lo <= bus.in_data;
          state  <= S_HDR3;
        end
        S_HDR3: if (xfer) begin
          if (cnt_d == '0) begin
            state <= S_END;
            run_q <= END_RUN;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (xfer) begin
          ram_we_q   <= 1'b1;
          ram_addr_q <= addr;
          ram_d_q    <= bus.in_data;
          addr       <= addr + ADDR_W'(1);
`ifdef PROG_LOADER_CKSUM_EN
          sum        <= cksum_add(sum, bus.in_data);
`endif
          if (cnt_zero) begin
            state <= S_END;
            run_q <= END_RUN;
          end
        end
`ifdef PROG_LOADER_CKSUM_EN
        S_CHK: if (xfer) begin
          if (bus.in_data == sum) begin
            state <= S_RUN;
            run_q <= (AUTO_RUN != 0);
          end else begin
            err_q <= 1'b1;
            state <= S_HDR0;
          end
        end
`endif
        S_RUN: begin
          done_q <= 1'b1;
          state  <= S_HDR0;
        end
        default: state <= S_HDR0;
      endcase
    end
  end

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_d    = ram_d_q;
  assign run          = run_q;
  assign done         = done_q;
  assign busy         = (state != S_HDR0);
`ifdef PROG_LOADER_CKSUM_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed images plus randomized images against an
// address/data/cycle reference model built from the header and payload.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst, cpu_idle, run, busy, done, err;

  prog_loader_if #(.ADDR_W(16)) bus ();

  prog_loader #(.ADDR_W(16), .AUTO_RUN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_idle (cpu_idle),
    .bus      (bus),
    .run      (run),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wr_q[$];
  int unsigned cyc = 0;
  int unsigned run_total = 0;
  int unsigned run_cyc = 0;
  int unsigned last_acc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  pay[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ram_we) wr_q.push_back('{cyc: cyc, addr: bus.ram_addr, data: bus.ram_d});
    if (run) begin
      run_total = run_total + 1;
      run_cyc   = cyc;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned guard;
    bit ok;
    guard = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!ok) begin
      #1;
      ok = (bus.in_ready === 1'b1);
      @(posedge clk);
      if (!ok) begin
        guard++;
        @(negedge clk);
        if (guard > 100) begin
          chk("accept_timeout", 32'(bus.in_ready), 32'd1);
          return;
        end
      end
    end
    @(negedge clk);
    last_acc = cyc;
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_ram_we",   32'(bus.ram_we),   0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_ram_d",    32'(bus.ram_d),    0);
    chk("rst_run",      32'(run),          0);
    chk("rst_busy",     32'(busy),         0);
    chk("rst_done",     32'(done),         0);
    chk("rst_err",      32'(err),          0);
  endtask

  task automatic run_image(input logic [15:0] a, input bit bad_ck, input int stall_at, input bit gaps);
    int unsigned w0, r0, len, n0;
    int unsigned acc[$];
    logic [7:0]  ck;
    logic [15:0] l16;
    bit          good;
    len  = pay.size();
    l16  = 16'(len);
    w0   = wr_q.size();
    r0   = run_total;
    ck   = 8'h00;
    good = !bad_ck;
    send_byte(a[7:0]);
    chk("hdr_clears_done", 32'(done), 0);
    chk("hdr_clears_err",  32'(err),  0);
    send_byte(a[15:8]);
    send_byte(l16[7:0]);
    send_byte(l16[15:8]);
    acc.push_back(last_acc);
    for (int i = 0; i < int'(len); i++) begin
      if (i == stall_at) begin
        cpu_idle     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = pay[i];
        #1;
        n0 = wr_q.size();
        chk("stall_busy", 32'(busy), 1);
        repeat (5) begin
          chk("stall_ready", 32'(bus.in_ready), 0);
          @(negedge clk);
          #1;
        end
        chk("stall_writes", 32'(wr_q.size() - n0), 0);
        cpu_idle = 1'b1;
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_byte(pay[i]);
      acc.push_back(last_acc);
      ck = ck + pay[i];
    end
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(bad_ck ? (ck ^ 8'h5A) : ck);
    acc.push_back(last_acc);
`endif
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wr_count", 32'(wr_q.size() - w0), len);
    for (int i = 0; i < int'(len); i++) begin
      if (w0 + i < wr_q.size()) begin
        chk("wr_addr", 32'(wr_q[w0+i].addr), 32'(16'(a + 16'(i))));
        chk("wr_data", 32'(wr_q[w0+i].data), 32'(pay[i]));
        chk("wr_cycle", wr_q[w0+i].cyc, acc[i+1]);
      end
    end
    chk("run_count", run_total - r0, good ? 32'd1 : 32'd0);
    if (good) chk("run_cycle", run_cyc, last_acc);
    if (stall_at < 0 && !gaps)
      for (int i = 1; i < acc.size(); i++) chk("back_to_back", acc[i] - acc[i-1], 1);
    chk("end_done",  32'(done), 32'(good));
    chk("end_err",   32'(err),  32'(!good));
    chk("end_busy",  32'(busy), 0);
    chk("end_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin : main
    int unsigned w0, r0, len;
    int          stall;
    logic [15:0] a;
    bit          bad;
    rst          = 1'b1;
    cpu_idle     = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 1);
    @(negedge clk);

    pay = '{8'hAA, 8'hBB, 8'hCC};
    run_image(16'h0100, 1'b0, -1, 1'b0);
    pay.delete();
    run_image(16'h0010, 1'b0, -1, 1'b0);
    pay = '{8'h11, 8'h22};
    run_image(16'hFFFF, 1'b0, -1, 1'b0);
    pay.delete();
    for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
    run_image(16'h2000, 1'b0, 3, 1'b0);

    // Reset after two of four payload bytes.
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    w0 = wr_q.size();
    r0 = run_total;
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(pay[0]);
    send_byte(pay[1]);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    chk("rst_wr_count", 32'(wr_q.size() - w0), 2);
    if (wr_q.size() >= w0 + 2) begin
      chk("rst_wr_addr0", 32'(wr_q[w0].addr),   32'h3000);
      chk("rst_wr_addr1", 32'(wr_q[w0+1].addr), 32'h3001);
      chk("rst_wr_data1", 32'(wr_q[w0+1].data), 32'h02);
    end
    chk("rst_run_count", run_total - r0, 0);
    rst = 1'b0;
    @(negedge clk);
    pay = '{8'h55, 8'h66, 8'h77};
    run_image(16'h3100, 1'b0, -1, 1'b0);

`ifdef PROG_LOADER_CKSUM_EN
    pay = '{8'h10, 8'h20, 8'h30};
    run_image(16'h4000, 1'b1, -1, 1'b0);
    pay = '{8'h40};
    run_image(16'h4100, 1'b0, -1, 1'b0);
`endif

    for (int t = 0; t < 25; t++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(256, 300) : $urandom_range(0, 16);
      a   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 8))) : 16'($urandom);
      pay.delete();
      for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
      stall = (len > 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      bad   = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
      bad   = ($urandom_range(0, 4) == 0);
`endif
      run_image(a, bad, stall, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
